// File: rtl/router_pkg.sv
// router_pkg
//   Shared definitions for the packet-router control path.
//   - state_t           : 4-bit encoded router FSM state
//   - DEF_NUM_CH        : default number of output channels
//   - DEF_ADDR_W        : default header address field width
//   - DEF_WAIT_TIMEOUT  : default WAIT_EMPTY timeout in cycles
//   - clog2()           : ceiling log2, never below 1, usable in parameter context
package router_pkg;

  typedef enum logic [3:0] {
    DECODE          = 4'd0,
    LFD             = 4'd1,
    LOAD_DATA       = 4'd2,
    FIFO_FULL       = 4'd3,
    LOAD_AFTER_FULL = 4'd4,
    LOAD_PARITY     = 4'd5,
    CHECK_PARITY    = 4'd6,
    WAIT_EMPTY      = 4'd7,
    DROP            = 4'd8
  } state_t;

  localparam int DEF_NUM_CH       = 3;
  localparam int DEF_ADDR_W       = 2;
  localparam int DEF_WAIT_TIMEOUT = 255;

  // Number of bits needed to index 'value' distinct items; minimum of 1 so
  // that a counter built from it always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// router_wait_timer
//   Loadable saturating up-counter with a terminal-count flag. Used by the
//   router FSM to bound the time spent waiting for a busy FIFO, and reusable
//   by the FIFO read-side timeout logic.
//   Parameters:
//     CNT_W    : counter width
//     TERMINAL : count value at which tc is raised
//   Ports:
//     clk        in   clock, rising edge
//     resetn     in   asynchronous active-low reset, clears the count
//     load       in   load load_value (has priority over enable)
//     load_value in   value loaded when load is high
//     enable     in   count up by one; holds at all-ones instead of wrapping
//     tc         out  high while the count equals TERMINAL
module router_wait_timer #(
  parameter int              CNT_W    = 8,
  parameter logic [CNT_W-1:0] TERMINAL = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             tc
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign tc = (count_reg == TERMINAL);

endmodule

// File: rtl/router_fsm_nch.sv
// router_fsm_nch
//   Packet-router control FSM for NUM_CH output channels. Decodes the header
//   address, sequences header/payload/parity writes into the selected FIFO,
//   stalls on a full FIFO, drops packets with an out-of-range address, and
//   abandons the wait for a non-empty FIFO after WAIT_TIMEOUT cycles.
//   Parameters:
//     NUM_CH       : output channels, 2..8
//     ADDR_W       : header address width, 2**ADDR_W >= NUM_CH
//     WAIT_TIMEOUT : maximum cycles in WAIT_EMPTY, >= 1
//   Ports:
//     clk, resetn                 clock / asynchronous active-low reset
//     data_in                     header address bits of the current byte
//     pkt_valid                   byte valid; low marks the parity byte
//     parity_done                 parity byte latched by the register block
//     low_pkt_valid               pkt_valid fell while stalled
//     fifo_full, fifo_empty       per-channel FIFO status
//     soft_reset                  per-channel read-side timeout reset
//     detect_add .. laf_state     state indicators (Moore)
//     rst_int_reg                 high in CHECK_PARITY
//     write_enb_reg               FIFO write enable
//     busy                        stalls the source
//     drop_state                  high while discarding a packet
//     ch_sel                      one-hot FIFO write select
//     timeout_err                 one-cycle pulse on WAIT_EMPTY timeout
module router_fsm_nch
  import router_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              pkt_valid,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  input  logic [NUM_CH-1:0] fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              full_state,
  output logic              laf_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              busy,
  output logic              drop_state,
  output logic [NUM_CH-1:0] ch_sel,
  output logic              timeout_err
);

  localparam int               CNT_W    = clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(WAIT_TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;

  // One-hot decodes of the latched address and of the incoming header.
  // Addresses at or above NUM_CH decode to all zeros, which both makes the
  // unsigned range check trivial and keeps status lookups in range.
  logic [NUM_CH-1:0] addr_onehot;
  logic [NUM_CH-1:0] din_onehot;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_addr_dec
      assign addr_onehot[gi] = (addr_reg == ADDR_W'(gi));
      assign din_onehot[gi]  = (data_in  == ADDR_W'(gi));
    end
  endgenerate

  logic sel_full;
  logic sel_empty;
  logic din_valid;
  logic din_empty;
  logic in_packet;
  logic soft_hit;

  assign sel_full  = |(fifo_full  & addr_onehot);
  assign sel_empty = |(fifo_empty & addr_onehot);
  assign din_valid = |din_onehot;
  assign din_empty = |(fifo_empty & din_onehot);

  // Soft reset only matters while a packet owns a channel; DECODE has no
  // channel yet and DROP never writes.
  assign in_packet = (state_reg != DECODE) && (state_reg != DROP);
  assign soft_hit  = in_packet && |(soft_reset & addr_onehot);

  logic tmr_load;
  logic tmr_tc;

  router_wait_timer #(
    .CNT_W    (CNT_W),
    .TERMINAL (TERM_CNT)
  ) u_wait_timer (
    .clk        (clk),
    .resetn     (resetn),
    .load       (tmr_load),
    .load_value ('0),
    .enable     (state_reg == WAIT_EMPTY),
    .tc         (tmr_tc)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= DECODE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    tmr_load    = 1'b0;
    timeout_err = 1'b0;

    if (soft_hit) begin
      state_next = DECODE;
      addr_next  = '0;
    end else begin
      case (state_reg)
        DECODE: begin
          if (pkt_valid) begin
            addr_next = data_in;
            if (!din_valid) begin
              state_next = DROP;
            end else if (din_empty) begin
              state_next = LFD;
            end else begin
              state_next = WAIT_EMPTY;
              tmr_load   = 1'b1;
            end
          end
        end
        LFD: begin
          state_next = LOAD_DATA;
        end
        LOAD_DATA: begin
          if (sel_full) begin
            state_next = FIFO_FULL;
          end else if (!pkt_valid) begin
            state_next = LOAD_PARITY;
          end
        end
        FIFO_FULL: begin
          if (!sel_full) begin
            state_next = LOAD_AFTER_FULL;
          end
        end
        LOAD_AFTER_FULL: begin
          if (parity_done) begin
            state_next = DECODE;
          end else if (low_pkt_valid) begin
            state_next = LOAD_PARITY;
          end else begin
            state_next = LOAD_DATA;
          end
        end
        LOAD_PARITY: begin
          state_next = CHECK_PARITY;
        end
        CHECK_PARITY: begin
          state_next = sel_full ? FIFO_FULL : DECODE;
        end
        WAIT_EMPTY: begin
          // The FIFO draining wins over a simultaneous timeout.
          if (sel_empty) begin
            state_next = LFD;
          end else if (tmr_tc) begin
            state_next  = DROP;
            timeout_err = 1'b1;
          end
        end
        DROP: begin
          // The low-pkt_valid cycle carries the parity byte, discarded here.
          if (!pkt_valid) begin
            state_next = DECODE;
          end
        end
        default: begin
          state_next = DECODE;
        end
      endcase
    end
  end

  assign detect_add    = (state_reg == DECODE);
  assign lfd_state     = (state_reg == LFD);
  assign ld_state      = (state_reg == LOAD_DATA);
  assign full_state    = (state_reg == FIFO_FULL);
  assign laf_state     = (state_reg == LOAD_AFTER_FULL);
  assign rst_int_reg   = (state_reg == CHECK_PARITY);
  assign drop_state    = (state_reg == DROP);
  assign write_enb_reg = (state_reg == LOAD_DATA) ||
                         (state_reg == LOAD_AFTER_FULL) ||
                         (state_reg == LOAD_PARITY);
  assign busy          = (state_reg != DECODE) &&
                         (state_reg != LOAD_DATA) &&
                         (state_reg != DROP);
  assign ch_sel        = in_packet ? addr_onehot : '0;

endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch
//   Directed bench for router_fsm_nch (NUM_CH=3, ADDR_W=2, WAIT_TIMEOUT=4).
//   Each step drives inputs shortly after a rising edge, then compares the
//   packed state-indicator outputs, ch_sel and timeout_err with hand-derived
//   values.
module tb_router_fsm_nch;

  localparam int NUM_CH       = 3;
  localparam int ADDR_W       = 2;
  localparam int WAIT_TIMEOUT = 4;

  // {detect_add, lfd, ld, full, laf, rst_int, write_enb, busy, drop}
  localparam logic [8:0] V_DEC  = 9'b100000000;
  localparam logic [8:0] V_LFD  = 9'b010000010;
  localparam logic [8:0] V_LD   = 9'b001000100;
  localparam logic [8:0] V_FF   = 9'b000100010;
  localparam logic [8:0] V_LAF  = 9'b000010110;
  localparam logic [8:0] V_LP   = 9'b000000110;
  localparam logic [8:0] V_CP   = 9'b000001010;
  localparam logic [8:0] V_WAIT = 9'b000000010;
  localparam logic [8:0] V_DROP = 9'b000000001;

  logic              clk;
  logic              resetn;
  logic [ADDR_W-1:0] data_in;
  logic              pkt_valid;
  logic              parity_done;
  logic              low_pkt_valid;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] soft_reset;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              full_state;
  logic              laf_state;
  logic              rst_int_reg;
  logic              write_enb_reg;
  logic              busy;
  logic              drop_state;
  logic [NUM_CH-1:0] ch_sel;
  logic              timeout_err;
  logic [8:0]        outs;

  int checks   = 0;
  int failures = 0;

  router_fsm_nch #(
    .NUM_CH       (NUM_CH),
    .ADDR_W       (ADDR_W),
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .data_in       (data_in),
    .pkt_valid     (pkt_valid),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .soft_reset    (soft_reset),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .full_state    (full_state),
    .laf_state     (laf_state),
    .rst_int_reg   (rst_int_reg),
    .write_enb_reg (write_enb_reg),
    .busy          (busy),
    .drop_state    (drop_state),
    .ch_sel        (ch_sel),
    .timeout_err   (timeout_err)
  );

  assign outs = {detect_add, lfd_state, ld_state, full_state, laf_state,
                 rst_int_reg, write_enb_reg, busy, drop_state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Let combinational outputs settle on the current inputs, then compare.
  task automatic expect_st(input string tag, input logic [8:0] vec,
                           input logic [NUM_CH-1:0] sel, input logic tmo);
    #1;
    $display("%0t %s outs=%b ch_sel=%b timeout_err=%b", $time, tag, outs, ch_sel, timeout_err);
    check_eq({tag, ".outs"},    32'(outs),        32'(vec));
    check_eq({tag, ".ch_sel"},  32'(ch_sel),      32'(sel));
    check_eq({tag, ".timeout"}, 32'(timeout_err), 32'(tmo));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn        = 1'b0;
    data_in       = '0;
    pkt_valid     = 1'b0;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;
    fifo_full     = '0;
    fifo_empty    = 3'b111;
    soft_reset    = '0;

    tick();
    tick();
    expect_st("reset", V_DEC, 3'b000, 1'b0);
    resetn = 1'b1;
    tick();

    // Normal packet to channel 1: 4 payload bytes then parity.
    data_in = 2'd1; pkt_valid = 1'b1;
    expect_st("p1.decode", V_DEC, 3'b000, 1'b0); tick();
    expect_st("p1.lfd", V_LFD, 3'b010, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      pkt_valid = (i < 3);
      expect_st($sformatf("p1.ld%0d", i), V_LD, 3'b010, 1'b0);
      tick();
    end
    expect_st("p1.lp", V_LP, 3'b010, 1'b0); tick();
    expect_st("p1.cp", V_CP, 3'b010, 1'b0); tick();
    expect_st("p1.done", V_DEC, 3'b000, 1'b0);

    // fifo_full[1] high for 3 cycles starting in LOAD_DATA.
    data_in = 2'd1; pkt_valid = 1'b1;
    expect_st("p2.decode", V_DEC, 3'b000, 1'b0); tick();
    expect_st("p2.lfd", V_LFD, 3'b010, 1'b0); tick();
    fifo_full = 3'b010;
    expect_st("p2.ld", V_LD, 3'b010, 1'b0); tick();
    expect_st("p2.ff0", V_FF, 3'b010, 1'b0); tick();
    expect_st("p2.ff1", V_FF, 3'b010, 1'b0); tick();
    fifo_full = 3'b000;
    expect_st("p2.ff2", V_FF, 3'b010, 1'b0); tick();
    expect_st("p2.laf", V_LAF, 3'b010, 1'b0); tick();
    pkt_valid = 1'b0;
    expect_st("p2.ld_last", V_LD, 3'b010, 1'b0); tick();
    expect_st("p2.lp", V_LP, 3'b010, 1'b0); tick();
    expect_st("p2.cp", V_CP, 3'b010, 1'b0); tick();
    expect_st("p2.done", V_DEC, 3'b000, 1'b0);

    // Invalid address 3 is dropped.
    data_in = 2'd3; pkt_valid = 1'b1;
    expect_st("p3.decode", V_DEC, 3'b000, 1'b0); tick();
    expect_st("p3.drop0", V_DROP, 3'b000, 1'b0); tick();
    pkt_valid = 1'b0;
    expect_st("p3.drop1", V_DROP, 3'b000, 1'b0); tick();
    expect_st("p3.done", V_DEC, 3'b000, 1'b0);

    // Channel 2 never empties: timeout after 4 cycles.
    fifo_empty = 3'b011; data_in = 2'd2; pkt_valid = 1'b1;
    expect_st("p4.decode", V_DEC, 3'b000, 1'b0); tick();
    for (int k = 0; k < 4; k++) begin
      expect_st($sformatf("p4.wait%0d", k), V_WAIT, 3'b100, (k == 3));
      tick();
    end
    pkt_valid = 1'b0;
    expect_st("p4.drop", V_DROP, 3'b000, 1'b0); tick();
    expect_st("p4.done", V_DEC, 3'b000, 1'b0);

    // Channel 2 empties in the same cycle the timeout would fire.
    fifo_empty = 3'b011; data_in = 2'd2; pkt_valid = 1'b1;
    expect_st("p5.decode", V_DEC, 3'b000, 1'b0); tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) fifo_empty = 3'b111;
      expect_st($sformatf("p5.wait%0d", k), V_WAIT, 3'b100, 1'b0);
      tick();
    end
    expect_st("p5.lfd", V_LFD, 3'b100, 1'b0); tick();
    pkt_valid = 1'b0;
    expect_st("p5.ld", V_LD, 3'b100, 1'b0); tick();
    expect_st("p5.lp", V_LP, 3'b100, 1'b0); tick();
    expect_st("p5.cp", V_CP, 3'b100, 1'b0); tick();
    expect_st("p5.done", V_DEC, 3'b000, 1'b0);

    // Soft reset: ignored in DECODE, other channel ignored, own channel aborts.
    data_in = 2'd0; pkt_valid = 1'b1; soft_reset = 3'b001;
    expect_st("p6.decode", V_DEC, 3'b000, 1'b0); tick();
    soft_reset = 3'b000;
    expect_st("p6.lfd", V_LFD, 3'b001, 1'b0); tick();
    soft_reset = 3'b100;
    expect_st("p6.ld_other", V_LD, 3'b001, 1'b0); tick();
    soft_reset = 3'b001;
    expect_st("p6.ld_own", V_LD, 3'b001, 1'b0); tick();
    soft_reset = 3'b000; pkt_valid = 1'b0;
    expect_st("p6.aborted", V_DEC, 3'b000, 1'b0);

    // Soft reset beats the full-FIFO branch of CHECK_PARITY.
    data_in = 2'd1; pkt_valid = 1'b1;
    expect_st("p7.decode", V_DEC, 3'b000, 1'b0); tick();
    expect_st("p7.lfd", V_LFD, 3'b010, 1'b0); tick();
    pkt_valid = 1'b0;
    expect_st("p7.ld", V_LD, 3'b010, 1'b0); tick();
    expect_st("p7.lp", V_LP, 3'b010, 1'b0); tick();
    fifo_full = 3'b010; soft_reset = 3'b010;
    expect_st("p7.cp", V_CP, 3'b010, 1'b0); tick();
    fifo_full = 3'b000; soft_reset = 3'b000;
    expect_st("p7.done", V_DEC, 3'b000, 1'b0);

    // Asynchronous reset in the middle of a payload.
    data_in = 2'd1; pkt_valid = 1'b1;
    expect_st("p8.decode", V_DEC, 3'b000, 1'b0); tick();
    expect_st("p8.lfd", V_LFD, 3'b010, 1'b0); tick();
    expect_st("p8.ld", V_LD, 3'b010, 1'b0);
    #2;
    resetn = 1'b0;
    expect_st("p8.async_reset", V_DEC, 3'b000, 1'b0);
    tick();
    resetn = 1'b1; pkt_valid = 1'b0;
    expect_st("p8.after", V_DEC, 3'b000, 1'b0); tick();
    expect_st("p8.idle", V_DEC, 3'b000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
